// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store into a single registered request on a
// req/gnt/rvalid data bus, with lane steering, load extension and a bus timeout.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg;
  logic [1:0]  off_reg;
  logic [2:0]  f3_reg;
  logic        start;
  logic        gnt_ok;
  logic        rv_ok;
  logic        timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  // Request qualification is purely combinational on the core's current inputs.
  always_comb begin
    illegal    = req_valid & ((funct3 == 3'b011) | (funct3 == 3'b110) |
                              (funct3 == 3'b111) | (mem_write & funct3[2]));
    misaligned = req_valid & ((((funct3 == 3'b001) | (funct3 == 3'b101)) & addr[0]) |
                              ((funct3 == 3'b010) & (addr[1:0] != 2'b00)));
  end

  assign start   = (state_reg == IDLE) & req_valid & ~misaligned & ~illegal;
  assign gnt_ok  = (state_reg == REQ) & bus_gnt;
  assign rv_ok   = (state_reg == WAIT) & bus_rvalid;
  // The transition out happens on the edge that brings the counter to 255.
  assign timeout = (((state_reg == REQ) & ~bus_gnt) | ((state_reg == WAIT) & ~bus_rvalid)) &
                   (cnt_reg == 8'd254);
  assign stall   = start | (state_reg == REQ) | (state_reg == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (bus_gnt)      state_next = bus_we ? DONE : WAIT;
        else if (timeout) state_next = DONE;
      end
      WAIT: begin
        if (bus_rvalid || timeout) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane steering of the outgoing request.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {addr[1], 1'b0};
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  // Load extraction uses the offset and size captured when the request started.
  always_comb begin
    lane_byte = bus_rdata[{off_reg, 3'b000} +: 8];
    lane_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_reg)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'd0, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_ext = {16'd0, lane_half};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
      cnt_reg   <= 8'd0;
      off_reg   <= 2'd0;
      f3_reg    <= 3'd0;
    end else begin
      bus_err <= timeout;
      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_next;
        bus_wdata <= wdata_next;
        off_reg   <= addr[1:0];
        f3_reg    <= funct3;
      end
      if (gnt_ok) begin
        bus_req <= 1'b0;
      end
      if (rv_ok) begin
        rdata <= load_ext;
      end
      if (timeout) begin
        bus_req <= 1'b0;
        rdata   <= 32'd0;
      end
      if (start || (gnt_ok && !bus_we)) begin
        cnt_reg <= 8'd0;
      end else if ((state_reg == REQ) || (state_reg == WAIT)) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The interface SHALL have clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The interface SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The interface SHALL have req_valid, input, 1 bit: the core's current instruction is a load or store.
REQ-004 The interface SHALL have mem_write, input, 1 bit: 1 = store, 0 = load; valid with req_valid.
REQ-005 The interface SHALL have funct3, input, 3 bits: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 The interface SHALL have addr, input, 32 bits: byte address (core ALUResult).
REQ-007 The interface SHALL have wdata, input, 32 bits: store data (core WriteData), low bits significant.
REQ-008 The interface SHALL have stall, output, 1 bit: core must hold PC and suppress register write while high.
REQ-009 The interface SHALL have rdata, output, 32 bits: extended load data (core ReadData), valid in DONE.
REQ-010 The interface SHALL have misaligned, output, 1 bit: combinational, alignment violation on the current request.
REQ-011 The interface SHALL have illegal, output, 1 bit: combinational, funct3 in {011, 110, 111} (stores: funct3[2]=1 also illegal).
REQ-012 The interface SHALL have bus_err, output, 1 bit: one-cycle pulse in DONE after a bus timeout.
REQ-013 The interface SHALL have bus_req, output, 1 bit: registered request to data memory.
REQ-014 The interface SHALL have bus_we, output, 1 bit: registered write enable.
REQ-015 The interface SHALL have bus_addr, output, 32 bits: registered word address, {addr[31:2], 2'b00}.
REQ-016 The interface SHALL have bus_be, output, 4 bits: registered byte enables.
REQ-017 The interface SHALL have bus_wdata, output, 32 bits: registered, lane-replicated store data.
REQ-018 The interface SHALL have bus_gnt, input, 1 bit: memory accepted the request this cycle.
REQ-019 The interface SHALL have bus_rvalid, input, 1 bit: bus_rdata is valid this cycle.
REQ-020 The interface SHALL have bus_rdata, input, 32 bits: read word from memory.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-022 In IDLE, when req_valid=1 and misaligned=illegal=0, the block SHALL register the bus outputs, set bus_req=1 and go to REQ.
REQ-023 In REQ, bus_req and all bus fields SHALL remain stable until bus_gnt=1.
REQ-024 On the grant edge, the block SHALL clear bus_req, then go to DONE for a store or to WAIT for a load.
REQ-025 In WAIT, on bus_rvalid=1 the block SHALL register the extended bus_rdata into rdata and go to DONE.
REQ-026 DONE SHALL last exactly one cycle, go to IDLE, and ignore req_valid.
REQ-027 stall SHALL be asserted (state==IDLE & req_valid & !misaligned & !illegal) | state==REQ | state==WAIT; stall SHALL be 0 in DONE.
REQ-028 misaligned SHALL be set by H/HU with addr[0]=1, or by W with addr[1:0]!=0; byte accesses are never misaligned.
REQ-029 On misaligned or illegal, the block SHALL start no bus transaction, keep stall=0, and stay in IDLE.
REQ-030 bus_be SHALL be: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111.
REQ-031 bus_wdata SHALL be: B = the low byte replicated ×4; H = the low half replicated ×2; W = wdata unchanged.
REQ-032 Load extraction SHALL take the byte at lane addr[1:0] (B/BU) or the half at lane addr[1] (H/HU), using the registered offset; B/H are sign-extended, BU/HU zero-extended, W is passed through.
REQ-033 For stores, rdata SHALL hold its previous value.
REQ-034 An 8-bit timeout counter SHALL clear on entry to REQ and on entry to WAIT, and increment each cycle in REQ/WAIT.
REQ-035 When the timeout counter reaches 255, the block SHALL clear bus_req, set rdata=0, go to DONE, and pulse bus_err.
REQ-036 bus_gnt or bus_rvalid arriving in IDLE or DONE, and bus_rvalid arriving in REQ, SHALL be ignored.
REQ-037 Minimum latency SHALL be a store with 2 stall cycles (gnt in the first REQ cycle) and a load with 3 stall cycles (rvalid in the first WAIT cycle).

Reset
REQ-038 While rst_n=0, the block SHALL be in state IDLE with bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, bus_err=0 and counter=0.
REQ-039 A reset mid-transaction SHALL drop bus_req immediately, and a late bus_rvalid after release SHALL be ignored.

Verification
REQ-040 SW addr=0x100, wdata=0xDEADBEEF, gnt on the first REQ cycle -> bus_addr=0x100, be=1111, we=1; stall is high for 2 cycles; DONE follows.
REQ-041 SB addr=0x103, wdata=0x000000A5 -> bus_addr=0x100, be=1000, bus_wdata=0xA5A5A5A5.
REQ-042 LB addr=0x202, bus_rdata=0x12F43456 -> rdata=0xFFFFFFF4; LBU at the same address -> rdata=0x000000F4; LHU addr=0x202 -> 0x000012F4.
REQ-043 LW addr=0x102 -> misaligned=1, stall=0, bus_req never asserted; funct3=011 -> illegal=1, no bus activity.
REQ-044 Load with bus_gnt held low -> after 255 REQ cycles bus_err pulses for 1 cycle, rdata=0, FSM returns to IDLE.
REQ-045 rst_n pulsed low while in WAIT, then bus_rvalid=1 -> bus_req=0, state IDLE, rdata=0, stall=0.
